// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - XNOR Fibonacci LFSR pseudo-random source with word-request handshake
// Optional build macro: LFSR_LOCKUP_RECOVER_EN (all-ones state steps to all-zeros)
module lfsr_prng #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic [WIDTH-1:0] state,
  output logic             busy,
  output logic             word_valid,
  output logic [OUT_W-1:0] word,
  output logic             wrap,
  output logic             stuck
);

  // Counter must hold OUT_W itself, since completion is detected on reaching it.
  localparam int               CNT_W    = (OUT_W < 2) ? 1 : $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W);

  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] next_state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             fb_bit;
  logic             accept;
  logic             step;

  // A new word can only start when idle; load always wins over a request.
  assign accept   = req && !busy && !load;
  assign step     = !load && (en || busy || accept);
  assign cnt_next = accept ? CNT_W'(1) : cnt + CNT_W'(1);
  assign stuck    = &state;

  // Feedback and next state; the recovery build forces the lock-up state out to zero.
  always_comb begin
    fb_bit     = ~^(state & TAPS);
    next_state = {state[WIDTH-2:0], fb_bit};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (&state) begin
      fb_bit     = 1'b0;
      next_state = '0;
    end
`endif
  end

  // Single-bit words have nothing to keep from the previous accumulator value.
  generate
    if (OUT_W == 1) begin : g_acc_single
      assign acc_next = fb_bit;
    end else begin : g_acc_shift
      assign acc_next = {acc[OUT_W-2:0], fb_bit};
    end
  endgenerate

  // State, wrap reference and word handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEED;
      ref_state  <= SEED;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word       <= '0;
      wrap       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      word_valid <= 1'b0;
      wrap       <= 1'b0;
      if (load) begin
        // Abort any word in progress; the partially built word is discarded.
        state     <= seed_in;
        ref_state <= seed_in;
        busy      <= 1'b0;
        cnt       <= '0;
      end else if (step) begin
        state <= next_state;
        wrap  <= (next_state == ref_state);
        if (accept || busy) begin
          acc <= acc_next;
          if (cnt_next == CNT_LAST) begin
            busy       <= 1'b0;
            cnt        <= '0;
            word       <= acc_next;
            word_valid <= 1'b1;
          end else begin
            busy <= 1'b1;
            cnt  <= cnt_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// tb/tb_lfsr_prng.sv - directed self-checking bench for lfsr_prng (WIDTH=4, TAPS=1100, OUT_W=8)
module tb_lfsr_prng;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] seed_in;
  logic       req;
  logic [3:0] state;
  logic       busy;
  logic       word_valid;
  logic [7:0] word;
  logic       wrap;
  logic       stuck;

  int n_vec  = 0;
  int n_miss = 0;

  // Free-run sequence from 0: fb = ~(s3 ^ s2), state <= {s[2:0], fb}.
  logic [3:0] seq_from0 [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
  // Free-run sequence from 9.
  logic [3:0] seq_from9 [15] = '{4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h1, 4'h3,
                                 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9};

  lfsr_prng #(
    .WIDTH(4),
    .TAPS (4'b1100),
    .SEED (4'h0),
    .OUT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .seed_in   (seed_in),
    .req       (req),
    .state     (state),
    .busy      (busy),
    .word_valid(word_valid),
    .word      (word),
    .wrap      (wrap),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0; req = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_wv",    32'(word_valid), 32'h0);
    check("rst_word",  32'(word), 32'h0);
    check("rst_wrap",  32'(wrap), 32'h0);
    check("rst_stuck", 32'(stuck), 32'h0);

    // Free run through a full period; wrap only on the return to 0
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("run_state[%0d]", i), 32'(state), 32'(seq_from0[i]));
      check($sformatf("run_wrap[%0d]", i), 32'(wrap), (i == 14) ? 32'h1 : 32'h0);
    end
    en = 1'b0;

    // Single word request: fb bits 1,1,1,0,1,1,0,0 -> 8'hEC
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("w1_busy_accept", 32'(busy), 32'h1);
    check("w1_state_accept", 32'(state), 32'h1);
    for (int k = 1; k < 7; k++) begin
      tick();
      check($sformatf("w1_busy[%0d]", k), 32'(busy), 32'h1);
      check($sformatf("w1_wv[%0d]", k), 32'(word_valid), 32'h0);
    end
    tick();
    check("w1_busy_done", 32'(busy), 32'h0);
    check("w1_wv_done", 32'(word_valid), 32'h1);
    check("w1_word", 32'(word), 32'hEC);
    check("w1_state", 32'(state), 32'hC);
    tick();
    check("w1_wv_pulse", 32'(word_valid), 32'h0);
    check("w1_word_held", 32'(word), 32'hEC);

    // Abort a word at cnt=3 with a load of 9
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("ab_busy_pre", 32'(busy), 32'h1);
    load = 1'b1; seed_in = 4'h9;
    tick();
    load = 1'b0;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_wv", 32'(word_valid), 32'h0);
    check("ab_word", 32'(word), 32'hEC);
    check("ab_state", 32'(state), 32'h9);
    check("ab_wrap", 32'(wrap), 32'h0);
    tick();
    check("ab_wv_later", 32'(word_valid), 32'h0);
    check("ab_state_idle", 32'(state), 32'h9);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("ab_run_state[%0d]", i), 32'(state), 32'(seq_from9[i]));
      check($sformatf("ab_run_wrap[%0d]", i), 32'(wrap), (i == 14) ? 32'h1 : 32'h0);
    end
    en = 1'b0;

    // req held high: back-to-back words, 16 consecutive steps from 0.
    // Second word uses fb from states C,9,2,5,A,4,8,0 = 1,0,1,0,0,0,0,1 -> 8'hA1
    do_reset();
    req = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      check($sformatf("b2b_wv[%0d]", c), 32'(word_valid), (c == 7 || c == 15) ? 32'h1 : 32'h0);
      check($sformatf("b2b_busy[%0d]", c), 32'(busy), (c == 7 || c == 15) ? 32'h0 : 32'h1);
      if (c == 7)  check("b2b_word1", 32'(word), 32'hEC);
      if (c == 15) check("b2b_word2", 32'(word), 32'hA1);
    end
    req = 1'b0;

    // Load all-ones then free run
    do_reset();
    load = 1'b1; seed_in = 4'hF;
    tick();
    load = 1'b0;
    check("lk_state_load", 32'(state), 32'hF);
    check("lk_stuck_load", 32'(stuck), 32'h1);
    check("lk_wrap_load", 32'(wrap), 32'h0);
    en = 1'b1;
    tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("lk_state_step1", 32'(state), 32'h0);
    check("lk_stuck_step1", 32'(stuck), 32'h0);
    tick();
    check("lk_state_step2", 32'(state), 32'h1);
`else
    check("lk_state_step1", 32'(state), 32'hF);
    check("lk_stuck_step1", 32'(stuck), 32'h1);
    tick();
    check("lk_state_step2", 32'(state), 32'hF);
    check("lk_stuck_step2", 32'(stuck), 32'h1);
`endif
    en = 1'b0;

    // Reset while busy and en high
    do_reset();
    req = 1'b1; en = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("rb_busy_pre", 32'(busy), 32'h1);
    check("rb_word_pre", 32'(word), 32'hEC);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0; en = 1'b0;
    check("rb_state", 32'(state), 32'h0);
    check("rb_busy", 32'(busy), 32'h0);
    check("rb_wv", 32'(word_valid), 32'h0);
    check("rb_word", 32'(word), 32'h0);
    check("rb_wrap", 32'(wrap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
